// File: rtl/lt24_pixel_writer_pkg.sv
// Shared constants, state types and the address-window word table for the LT24 pixel writer.
package lt24_pixel_writer_pkg;

   localparam logic [15:0] CMD_CASET  = 16'h002A;
   localparam logic [15:0] CMD_PASET  = 16'h002B;
   localparam logic [15:0] CMD_RAMWR  = 16'h002C;
   localparam int          ADDR_WORDS = 11;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_PIXEL, ST_DROP} state_t;
   typedef enum logic [1:0] {PH_IDLE, PH_LOW, PH_HIGH} phase_t;

   // Returns {RS, data} for word idx of the column/page window sequence.
   function automatic logic [16:0] addr_word(
      input logic [3:0]  idx,
      input logic [7:0]  x,
      input logic [8:0]  y,
      input logic [15:0] x_last,
      input logic [15:0] y_last
   );
      logic [15:0] x16;
      logic [15:0] y16;
      logic [16:0] w;
      x16 = {8'h00, x};
      y16 = {7'h00, y};
      case (idx)
         4'd0:    w = {1'b0, CMD_CASET};
         4'd1:    w = {1'b1, 8'h00, x16[15:8]};
         4'd2:    w = {1'b1, 8'h00, x16[7:0]};
         4'd3:    w = {1'b1, 8'h00, x_last[15:8]};
         4'd4:    w = {1'b1, 8'h00, x_last[7:0]};
         4'd5:    w = {1'b0, CMD_PASET};
         4'd6:    w = {1'b1, 8'h00, y16[15:8]};
         4'd7:    w = {1'b1, 8'h00, y16[7:0]};
         4'd8:    w = {1'b1, 8'h00, y_last[15:8]};
         4'd9:    w = {1'b1, 8'h00, y_last[7:0]};
         default: w = {1'b0, CMD_RAMWR};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lt24_pixel_writer_bus_word.sv
// Two-cycle LT24 write strobe: a sampled start launches a LOW cycle, then a HIGH cycle (done).
// Starting again during HIGH chains words with CS_n held low.
module lt24_bus_word
   import lt24_pixel_writer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_start,
   input  logic [15:0] i_data,
   input  logic        i_rs,
   output logic        o_wr_n,
   output logic        o_cs_n,
   output logic        o_rs,
   output logic [15:0] o_data,
   output logic        o_low,
   output logic        o_done
);

   phase_t      r_phase;
   logic        r_wr_n;
   logic        r_cs_n;
   logic        r_rs;
   logic [15:0] r_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase <= PH_IDLE;
         r_wr_n  <= 1'b1;
         r_cs_n  <= 1'b1;
         r_rs    <= 1'b1;
         r_data  <= 16'h0000;
      end else if (i_start && r_phase != PH_LOW) begin
         r_phase <= PH_LOW;
         r_wr_n  <= 1'b0;
         r_cs_n  <= 1'b0;
         r_rs    <= i_rs;
         r_data  <= i_data;
      end else if (r_phase == PH_LOW) begin
         r_phase <= PH_HIGH;
         r_wr_n  <= 1'b1;
      end else begin
         r_phase <= PH_IDLE;
         r_cs_n  <= 1'b1;
      end
   end

   assign o_wr_n = r_wr_n;
   assign o_cs_n = r_cs_n;
   assign o_rs   = r_rs;
   assign o_data = r_data;
   assign o_low  = (r_phase == PH_LOW);
   assign o_done = (r_phase == PH_HIGH);

endmodule

// File: rtl/lt24_pixel_writer.sv
// LT24 pixel writer: turns (x, y, RGB565) requests into LT24 bus transactions.
// Define LT24_PIXEL_WRITER_STREAM_EN to send consecutive pixels without re-sending the window.
module lt24_pixel_writer
   import lt24_pixel_writer_pkg::*;
#(
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  xAddr,
   input  logic [8:0]  yAddr,
   input  logic [15:0] pixelData,
   input  logic        pixelWrite,
   output logic        pixelReady,
   output logic        pixelDropped,
   output logic        LT24Wr_n,
   output logic        LT24Rd_n,
   output logic        LT24CS_n,
   output logic        LT24RS,
   output logic [15:0] LT24Data
);

`ifdef LT24_PIXEL_WRITER_STREAM_EN
   localparam bit STREAM_EN = 1'b1;
`else
   localparam bit STREAM_EN = 1'b0;
`endif

   localparam logic [15:0] X_LAST16 = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LAST16 = 16'(HEIGHT - 1);
   localparam logic [7:0]  X_LAST   = X_LAST16[7:0];
   localparam logic [8:0]  Y_LAST   = Y_LAST16[8:0];

   state_t      r_state;
   logic [3:0]  r_idx;
   logic        r_ready;
   logic        r_dropped;
   logic [7:0]  r_x, r_x0, r_ex;
   logic [8:0]  r_y, r_ey;
   logic [15:0] r_pix;
   logic        r_valid;
   logic        r_start;
   logic [15:0] r_wdata;
   logic        r_wrs;

   logic        w_accept;
   logic        w_in_range;
   logic        w_hit;
   logic        w_bus_low;
   logic        w_bus_done;
   logic [16:0] w_next_word;

   assign w_accept    = pixelWrite && r_ready;
   assign w_in_range  = (xAddr <= X_LAST) && (yAddr <= Y_LAST);
   assign w_hit       = r_valid && (xAddr == r_ex) && (yAddr == r_ey);
   assign w_next_word = addr_word(r_idx + 4'd1, r_x, r_y, X_LAST16, Y_LAST16);

   // The next word is queued while the bus is in LOW so it is sampled on the HIGH->LOW edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_idx     <= 4'd0;
         r_ready   <= 1'b0;
         r_dropped <= 1'b0;
         r_x       <= 8'd0;
         r_y       <= 9'd0;
         r_pix     <= 16'h0000;
         r_x0      <= 8'd0;
         r_ex      <= 8'd0;
         r_ey      <= 9'd0;
         r_valid   <= 1'b0;
         r_start   <= 1'b0;
         r_wdata   <= 16'h0000;
         r_wrs     <= 1'b1;
      end else begin
         r_start   <= 1'b0;
         r_dropped <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_ready <= 1'b0;
                  r_x     <= xAddr;
                  r_y     <= yAddr;
                  r_pix   <= pixelData;
                  if (!w_in_range) begin
                     r_state   <= ST_DROP;
                     r_dropped <= 1'b1;
                  end else if (w_hit) begin
                     r_state <= ST_PIXEL;
                     r_start <= 1'b1;
                     r_wdata <= pixelData;
                     r_wrs   <= 1'b1;
                  end else begin
                     r_state <= ST_ADDR;
                     r_idx   <= 4'd0;
                     r_x0    <= xAddr;
                     r_start <= 1'b1;
                     r_wdata <= CMD_CASET;
                     r_wrs   <= 1'b0;
                  end
               end
            end
            ST_ADDR: begin
               if (w_bus_low) begin
                  r_start <= 1'b1;
                  if (r_idx == 4'(ADDR_WORDS - 1)) begin
                     r_state <= ST_PIXEL;
                     r_wdata <= r_pix;
                     r_wrs   <= 1'b1;
                  end else begin
                     r_idx            <= r_idx + 4'd1;
                     {r_wrs, r_wdata} <= w_next_word;
                  end
               end
            end
            ST_PIXEL: begin
               // done while r_start is set still belongs to the last window word
               if (w_bus_done && !r_start) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_idx   <= 4'd0;
                  r_valid <= STREAM_EN;
                  if (r_x != X_LAST) begin
                     r_ex <= r_x + 8'd1;
                     r_ey <= r_y;
                  end else if (r_y != Y_LAST) begin
                     r_ex <= r_x0;
                     r_ey <= r_y + 9'd1;
                  end else begin
                     r_valid <= 1'b0;
                  end
               end
            end
            ST_DROP: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   lt24_bus_word u_bus (
      .clock   (clock),
      .reset   (reset),
      .i_start (r_start),
      .i_data  (r_wdata),
      .i_rs    (r_wrs),
      .o_wr_n  (LT24Wr_n),
      .o_cs_n  (LT24CS_n),
      .o_rs    (LT24RS),
      .o_data  (LT24Data),
      .o_low   (w_bus_low),
      .o_done  (w_bus_done)
   );

   assign pixelReady   = r_ready;
   assign pixelDropped = r_dropped;
   assign LT24Rd_n     = 1'b1;

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// Bench for lt24_pixel_writer: expected bus words go into a queue and are popped as Wr_n pulses appear.
// Define LT24_PIXEL_WRITER_STREAM_EN for both bench and design to cover the streamed path.
`timescale 1ns/1ps
module tb_lt24_pixel_writer;

   localparam int W = 240;
   localparam int H = 320;
`ifdef LT24_PIXEL_WRITER_STREAM_EN
   localparam bit STREAM = 1'b1;
`else
   localparam bit STREAM = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  xAddr = 8'd0;
   logic [8:0]  yAddr = 9'd0;
   logic [15:0] pixelData = 16'h0000;
   logic        pixelWrite = 1'b0;
   logic        pixelReady, pixelDropped;
   logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
   logic [15:0] LT24Data;

   int          checks = 0;
   int          errors = 0;
   logic [16:0] exp_q[$];
   logic        prev_low = 1'b0;
   logic [16:0] prev_word = '0;

   // reference model of the stream state
   bit          m_valid = 1'b0;
   int          m_ex = 0, m_ey = 0, m_x0 = 0;

   lt24_pixel_writer #(.WIDTH(W), .HEIGHT(H)) dut (
      .clock        (clock),
      .reset        (reset),
      .xAddr        (xAddr),
      .yAddr        (yAddr),
      .pixelData    (pixelData),
      .pixelWrite   (pixelWrite),
      .pixelReady   (pixelReady),
      .pixelDropped (pixelDropped),
      .LT24Wr_n     (LT24Wr_n),
      .LT24Rd_n     (LT24Rd_n),
      .LT24CS_n     (LT24CS_n),
      .LT24RS       (LT24RS),
      .LT24Data     (LT24Data)
   );

   always #5 clock = ~clock;

   // Bus monitor: every LOW cycle is a word; the following HIGH cycle must hold it.
   always @(negedge clock) begin
      if (LT24Wr_n === 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_word: unexpected word rs=%b data=%h", LT24RS, LT24Data);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({LT24RS, LT24Data} !== e)
               begin errors++; $display("FAIL bus_word: got rs=%b data=%h, want rs=%b data=%h", LT24RS, LT24Data, e[16], e[15:0]); end
         end
         checks++;
         if (LT24CS_n !== 1'b0 || LT24Rd_n !== 1'b1)
            begin errors++; $display("FAIL strobe_low: cs_n=%b rd_n=%b, want 0/1", LT24CS_n, LT24Rd_n); end
         prev_low  = 1'b1;
         prev_word = {LT24RS, LT24Data};
      end else begin
         if (prev_low && !reset) begin
            checks++;
            if ({LT24RS, LT24Data} !== prev_word || LT24CS_n !== 1'b0 || LT24Rd_n !== 1'b1)
               begin errors++; $display("FAIL word_hold: rs/data=%h cs_n=%b rd_n=%b, want %h/0/1", {LT24RS, LT24Data}, LT24CS_n, LT24Rd_n, prev_word); end
         end
         prev_low = 1'b0;
      end
   end

   function automatic logic [16:0] addr_word(input int i, input int x, input int y);
      case (i)
         0:       return {1'b0, 16'h002A};
         1:       return {1'b1, 16'(x / 256)};
         2:       return {1'b1, 16'(x % 256)};
         3:       return {1'b1, 16'((W - 1) / 256)};
         4:       return {1'b1, 16'((W - 1) % 256)};
         5:       return {1'b0, 16'h002B};
         6:       return {1'b1, 16'(y / 256)};
         7:       return {1'b1, 16'(y % 256)};
         8:       return {1'b1, 16'((H - 1) / 256)};
         9:       return {1'b1, 16'((H - 1) % 256)};
         default: return {1'b0, 16'h002C};
      endcase
   endfunction

   // Pushes the expected words for one request and returns its expected ready latency.
   task automatic model_pixel(input int x, input int y, input logic [15:0] d, output int lat);
      bit full;
      if (x >= W || y >= H) begin
         lat = 1;
         return;
      end
      full = !(STREAM && m_valid && x == m_ex && y == m_ey);
      if (full) begin
         for (int i = 0; i < 11; i++) exp_q.push_back(addr_word(i, x, y));
         m_x0 = x;
      end
      exp_q.push_back({1'b1, d});
      if (x < W - 1) begin
         m_ex = x + 1; m_ey = y; m_valid = 1'b1;
      end else if (y < H - 1) begin
         m_ex = m_x0; m_ey = y + 1; m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      lat = full ? 25 : 3;
   endtask

   // Issues one request and measures cycles until pixelReady returns; junk requests are held while busy.
   task automatic drive_pixel(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                              output int lat, output logic drop_t1, output logic cs_t1,
                              output logic drop_end);
      int w;
      w = 0;
      while (pixelReady !== 1'b1 && w < 50) begin
         @(posedge clock); #1; w++;
      end
      xAddr = x; yAddr = y; pixelData = d; pixelWrite = 1'b1;
      @(posedge clock); #1;
      drop_t1    = pixelDropped;
      cs_t1      = LT24CS_n;
      xAddr      = 8'($urandom);
      yAddr      = 9'($urandom);
      pixelData  = 16'($urandom);
      lat = 0;
      while (pixelReady !== 1'b1 && lat < 60) begin
         @(posedge clock); #1; lat++;
      end
      pixelWrite = 1'b0;
      drop_end   = pixelDropped;
      if (pixelReady !== 1'b1) lat = -1;
      $display("pixel (%0d,%0d) data %h ready after %0d cycles", x, y, d, lat);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (pixelReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pixelReady); end
      checks++;
      if ({LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS} !== 4'b1111)
         begin errors++; $display("FAIL reset_strobes: cs/wr/rd/rs=%b want 1111", {LT24CS_n, LT24Wr_n, LT24Rd_n, LT24RS}); end
      checks++;
      if (LT24Data !== 16'h0000 || pixelDropped !== 1'b0)
         begin errors++; $display("FAIL reset_data: data=%h dropped=%b want 0000/0", LT24Data, pixelDropped); end
      reset = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (pixelReady !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", pixelReady); end
      m_valid = 1'b0; m_ex = 0; m_ey = 0; m_x0 = 0;
   endtask

   task automatic test_first_pixel();
      logic [16:0] words [12] = '{17'h0002A, 17'h10000, 17'h10005, 17'h10000, 17'h100EF, 17'h0002B,
                                  17'h10000, 17'h10007, 17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};
      int lat; logic d1, c1, d2;
      foreach (words[i]) exp_q.push_back(words[i]);
      m_valid = 1'b1; m_ex = 6; m_ey = 7; m_x0 = 5;
      drive_pixel(8'd5, 9'd7, 16'hF800, lat, d1, c1, d2);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL first_latency: got %0d want 25", lat); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL first_words: %0d words missing, want 0", exp_q.size()); end
      checks++;
      if (d1 !== 1'b0 || c1 !== 1'b1) begin errors++; $display("FAIL first_t1: dropped=%b cs_n=%b want 0/1", d1, c1); end
   endtask

   task automatic test_back_to_back();
      int lat, el; logic d1, c1, d2;
      model_pixel(6, 7, 16'h07E0, el);
      drive_pixel(8'd6, 9'd7, 16'h07E0, lat, d1, c1, d2);
      checks++;
      if (lat !== (STREAM ? 3 : 25)) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, STREAM ? 3 : 25); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_words: %0d words missing, want 0", exp_q.size()); end
   endtask

   task automatic test_row_wrap();
      int xs [3] = '{238, 239, 238};
      int ys [3] = '{10, 10, 11};
      int want [3];
      int lat, el; logic d1, c1, d2;
      want = '{25, STREAM ? 3 : 25, STREAM ? 3 : 25};
      for (int i = 0; i < 3; i++) begin
         model_pixel(xs[i], ys[i], 16'(16'h1000 + i), el);
         drive_pixel(8'(xs[i]), 9'(ys[i]), 16'(16'h1000 + i), lat, d1, c1, d2);
         checks++;
         if (lat !== want[i]) begin errors++; $display("FAIL wrap_latency[%0d]: got %0d want %0d", i, lat, want[i]); end
         checks++;
         if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_words[%0d]: %0d words missing, want 0", i, exp_q.size()); end
      end
   endtask

   task automatic test_drop();
      int xs [3] = '{240, 0, 0};
      int ys [3] = '{0, 320, 0};
      int lat, el; logic d1, c1, d2;
      for (int i = 0; i < 2; i++) begin
         model_pixel(xs[i], ys[i], 16'hDEAD, el);
         drive_pixel(8'(xs[i]), 9'(ys[i]), 16'hDEAD, lat, d1, c1, d2);
         checks++;
         if (d1 !== 1'b1 || d2 !== 1'b0) begin errors++; $display("FAIL drop_pulse[%0d]: t1=%b next=%b want 1/0", i, d1, d2); end
         checks++;
         if (c1 !== 1'b1 || lat !== 1) begin errors++; $display("FAIL drop_bus[%0d]: cs_n=%b latency=%0d want 1/1", i, c1, lat); end
      end
      model_pixel(xs[2], ys[2], 16'h0F0F, el);
      drive_pixel(8'(xs[2]), 9'(ys[2]), 16'h0F0F, lat, d1, c1, d2);
      checks++;
      if (lat !== 25 || d1 !== 1'b0) begin errors++; $display("FAIL after_drop: latency=%0d dropped=%b want 25/0", lat, d1); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL after_drop_words: %0d words missing, want 0", exp_q.size()); end
   endtask

   task automatic test_end_of_window();
      int lat, el; logic d1, c1, d2;
      model_pixel(239, 319, 16'hAAAA, el);
      drive_pixel(8'd239, 9'd319, 16'hAAAA, lat, d1, c1, d2);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL eow_last: got %0d want 25", lat); end
      model_pixel(0, 0, 16'h5555, el);
      drive_pixel(8'd0, 9'd0, 16'h5555, lat, d1, c1, d2);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL eow_restart: got %0d want 25", lat); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL eow_words: %0d words missing, want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_addr();
      int lat, el; logic d1, c1, d2;
      model_pixel(50, 60, 16'h1234, el);
      drive_pixel(8'd50, 9'd60, 16'h1234, lat, d1, c1, d2);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL mid_setup: got %0d want 25", lat); end
      model_pixel(100, 100, 16'hABCD, el);
      xAddr = 8'd100; yAddr = 9'd100; pixelData = 16'hABCD; pixelWrite = 1'b1;
      @(posedge clock); #1;
      pixelWrite = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      checks++;
      if (LT24Wr_n !== 1'b0 || LT24Data !== 16'd239)
         begin errors++; $display("FAIL mid_word4: wr_n=%b data=%h want 0/00ef", LT24Wr_n, LT24Data); end
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (LT24CS_n !== 1'b1 || LT24Wr_n !== 1'b1 || pixelReady !== 1'b0)
         begin errors++; $display("FAIL mid_abort: cs_n=%b wr_n=%b ready=%b want 1/1/0", LT24CS_n, LT24Wr_n, pixelReady); end
      exp_q.delete();
      m_valid = 1'b0; m_ex = 0; m_ey = 0; m_x0 = 0;
      @(posedge clock); #1;
      reset = 1'b0;
      model_pixel(51, 60, 16'h4321, el);
      drive_pixel(8'd51, 9'd60, 16'h4321, lat, d1, c1, d2);
      checks++;
      if (lat !== 25) begin errors++; $display("FAIL mid_restart: got %0d want 25", lat); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL mid_restart_words: %0d words missing, want 0", exp_q.size()); end
   endtask

   task automatic test_random();
      int x, y, lat, el; logic d1, c1, d2; logic [15:0] d;
      for (int n = 0; n < 16; n++) begin
         d = 16'($urandom);
         if (m_valid && $urandom_range(0, 1) == 1) begin
            x = m_ex; y = m_ey;
         end else if ($urandom_range(0, 7) == 0) begin
            x = $urandom_range(240, 255); y = $urandom_range(0, 511);
         end else begin
            x = $urandom_range(0, 239); y = $urandom_range(0, 319);
         end
         model_pixel(x, y, d, el);
         drive_pixel(8'(x), 9'(y), d, lat, d1, c1, d2);
         checks++;
         if (lat !== el) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, el); end
         checks++;
         if (exp_q.size() != 0) begin errors++; $display("FAIL rand_words[%0d]: %0d words missing, want 0", n, exp_q.size()); end
      end
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_back_to_back();
      test_row_wrap();
      test_drop();
      test_end_of_window();
      test_reset_mid_addr();
      test_random();
      repeat (4) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lt24_pixel_writer.md
LT24_PIXEL_WRITER -- requirements
Module: lt24_pixel_writer

Interface
REQ-001 Parameter WIDTH, default 240, panel columns.
REQ-002 Parameter HEIGHT, default 320, panel rows.
REQ-003 clock  input  1  single clock for the whole block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 xAddr  input  8  pixel column.
REQ-006 yAddr  input  9  pixel row.
REQ-007 pixelData  input  16  RGB565 colour.
REQ-008 pixelWrite  input  1  pixel request, qualified by pixelReady.
REQ-009 pixelReady  output  1  high only in IDLE; a pixel is accepted on any edge where pixelWrite && pixelReady.
REQ-010 pixelDropped  output  1  one-cycle pulse when an accepted pixel is out of range.
REQ-011 LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS  output  1 each  LT24 bus strobes.
REQ-012 LT24Data  output  16  LT24 bus data.

Function
REQ-013 Bus word: 2 cycles, with Wr_n=0 in the first and Wr_n=1 in the second. Data and RS are stable across both cycles.
REQ-014 RS=0 for command words and RS=1 for parameter and pixel words.
REQ-015 LT24Rd_n SHALL be held at 1 at all times.
REQ-016 CS_n=0 from the first Wr_n-low cycle of a transaction to its last word's Wr_n-high cycle, and 1 otherwise.
REQ-017 FSM states: IDLE, ADDR, PIXEL, DROP.
  - Each bus state has a LOW/HIGH sub-phase.
  - A 4-bit word index steps through ADDR.
REQ-018 Acceptance with x>=WIDTH or y>=HEIGHT goes to DROP.
  - pixelDropped=1 for 1 cycle and no bus activity occurs.
  - The next cycle returns to IDLE.
  - The stream state is unchanged.
REQ-019 Acceptance with stream valid and (x,y) equal to the expected address goes straight to PIXEL.
REQ-020 Any other acceptance goes to ADDR, which emits 11 words in order:
  - 0x2A command.
  - x[15:8], x[7:0].
  - (WIDTH-1)[15:8], (WIDTH-1)[7:0].
  - 0x2B command.
  - y[15:8], y[7:0].
  - (HEIGHT-1)[15:8], (HEIGHT-1)[7:0].
  - 0x2C command.
  - The 8-bit and 9-bit addresses are zero-extended to 16 bits.
  - After the 11th word the FSM goes to PIXEL.
REQ-021 ADDR latches window origin x0=x and y0=y.
REQ-022 PIXEL emits pixelData (captured at acceptance) as 1 word, then returns to IDLE.
REQ-023 Latency on the streamed path: acceptance at edge T0, Wr_n low in T0+1, high in T0+2, pixelReady=1 in T0+3. One pixel takes 3 cycles.
REQ-024 Latency on the full path: 11 ADDR words plus 1 PIXEL word, so pixelReady=1 in T0+25.
REQ-025 After each PIXEL word the expected address is computed as follows:
  - x<WIDTH-1: (x+1, y).
  - x==WIDTH-1 and y<HEIGHT-1: (x0, y+1).
  - x==WIDTH-1 and y==HEIGHT-1: the stream is invalidated (end of window).
REQ-026 pixelWrite while pixelReady=0 SHALL be ignored and not queued. Input changes during a transaction SHALL NOT affect the bus.

Reset
REQ-027 On reset the outputs take these values:
  - State=IDLE, word index 0.
  - pixelReady=0 in the reset cycle and 1 from the following cycle.
  - pixelDropped=0.
  - CS_n=1, Wr_n=1, Rd_n=1, RS=1, LT24Data=0.
  - Stream invalid; x0, y0 and the expected address all 0.
REQ-028 Reset mid-transaction SHALL abort on the next edge with no further Wr_n pulses. The first pixel after reset always takes the full ADDR path.

Configuration
REQ-029 Macro LT24_PIXEL_WRITER_STREAM_EN, when defined, enables the streamed path of REQ-019 and REQ-025.
REQ-030 When the macro is undefined, the stream is never valid and every in-range pixel takes the 25-cycle ADDR+PIXEL path. Ports SHALL be identical in both builds.

Structure
REQ-031 A shared package SHALL hold:
  - The command constants 0x2A, 0x2B, 0x2C.
  - The FSM state enumeration.
  - The ADDR word count 11.
REQ-032 One sub-module, lt24_bus_word, SHALL generate the 2-cycle LOW/HIGH strobe from a start input, a data input and an RS input. It returns done in the HIGH cycle.

Verification
REQ-033 First pixel after reset, (5,7)=0xF800, gives 12 words:
  - 0x2A,0,5,0,239 then 0x2B,0,7,1,63 then 0x2C, all with RS=0 on commands.
  - Then 0xF800 with RS=1.
  - pixelReady returns after 25 cycles.
REQ-034 With STREAM_EN, back-to-back (5,7) then (6,7) gives a single data word for the second pixel, and pixelReady returns after 3 cycles.
REQ-035 With STREAM_EN, after a full path at (238,10), pixels (239,10) then (238,11) both take the streamed path (expected wraps to x0=238).
REQ-036 An out-of-range pixel (240,0) gives a 1-cycle pixelDropped pulse, CS_n stays 1, and the next pixel (0,0) takes the full path.
REQ-037 With STREAM_EN, after (239,319) the following (0,0) takes the full 11-word path.
REQ-038 Reset asserted at word 4 of ADDR gives, on the next edge, CS_n=1, Wr_n=1, pixelReady=0. The following pixel restarts with 0x2A.
REQ-039 Without the macro, (5,7) then (6,7) both take the 25-cycle path.
